// File: rtl/pipelined_addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_addsub_pkg : shared sizing helpers and stage record type    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipelined_addsub_pkg;

  localparam int c_def_width = 34;
  localparam int c_def_seg_w = 17;

  function automatic int calc_nseg(input int width, input int seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  function automatic int calc_last_seg_w(input int width, input int seg_w);
    return width - (calc_nseg(width, seg_w) - 1) * seg_w;
  endfunction

  localparam int c_last_seg_w = calc_last_seg_w(c_def_width, c_def_seg_w);

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/addsub_seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_seg : combinational W-bit segment adder with MSB carry tap     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module addsub_seg
  import pipelined_addsub_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] w_full;

  assign w_full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s        = w_full[W-1:0];
  assign co       = w_full[W];
  // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c_in.
  assign c_msb_in = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_addsub : segmented, valid/ready pipelined add/subtract      |
// | Optional saturation: define PIPELINED_ADDSUB_SATURATE_EN. Rev 1.0     |
// +----------------------------------------------------------------------+
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int SEG_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPELINED_ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int c_nseg   = calc_nseg(WIDTH, SEG_W);
  localparam int c_last_w = calc_last_seg_w(WIDTH, SEG_W);

  stage_ctl_t [c_nseg-1:0]            r_ctl;
  logic       [c_nseg-1:0][WIDTH-1:0] r_a;
  logic       [c_nseg-1:0][WIDTH-1:0] r_b;
  logic       [c_nseg-1:0][WIDTH-1:0] r_sum;
  logic       [c_nseg-1:0]            r_sat;
  logic                               r_cout;
  logic                               r_ovf;
  logic                               r_zero;

  logic                               w_adv;
  logic                               w_sat_req;
  logic       [c_nseg-1:0][WIDTH-1:0] w_a_in;
  logic       [c_nseg-1:0][WIDTH-1:0] w_b_in;
  logic       [c_nseg-1:0][WIDTH-1:0] w_sum_prev;
  logic       [c_nseg-1:0][WIDTH-1:0] w_seg_sum;
  logic       [c_nseg-1:0]            w_ci;
  logic       [c_nseg-1:0]            w_vld_in;
  logic       [c_nseg-1:0]            w_sat_in;
  logic       [c_nseg-1:0]            w_co;
  logic       [c_nseg-1:0]            w_cmsb;
  logic       [WIDTH-1:0]             w_raw_sum;
  logic       [WIDTH-1:0]             w_final_sum;
  logic                               w_ovf;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  assign w_sat_req = sat;
`else
  assign w_sat_req = 1'b0;
`endif

  // One global advance: a stalled output freezes every stage together.
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Stage inputs: ports for stage 0, previous stage registers otherwise.
  always_comb begin
    w_a_in[0]     = a;
    w_b_in[0]     = sub ? ~b : b;
    w_ci[0]       = sub | cin;
    w_vld_in[0]   = in_valid;
    w_sat_in[0]   = w_sat_req;
    w_sum_prev[0] = '0;
    for (int k = 1; k < c_nseg; k++) begin
      w_a_in[k]     = r_a[k-1];
      w_b_in[k]     = r_b[k-1];
      w_ci[k]       = r_ctl[k-1].carry;
      w_vld_in[k]   = r_ctl[k-1].valid;
      w_sat_in[k]   = r_sat[k-1];
      w_sum_prev[k] = r_sum[k-1];
    end
  end

  for (genvar k = 0; k < c_nseg; k++) begin : g_stage
    localparam int c_lo = k * SEG_W;
    localparam int c_sw = (k == c_nseg - 1) ? c_last_w : SEG_W;

    logic [c_sw-1:0] w_s;

    addsub_seg #(
      .W (c_sw)
    ) u_seg (
      .a        (w_a_in[k][c_lo +: c_sw]),
      .b        (w_b_in[k][c_lo +: c_sw]),
      .ci       (w_ci[k]),
      .s        (w_s),
      .co       (w_co[k]),
      .c_msb_in (w_cmsb[k])
    );

    assign w_seg_sum[k] = WIDTH'(w_s) << c_lo;
  end

  // Final stage: flags from the top segment, saturation on the full result.
  always_comb begin
    w_raw_sum   = w_sum_prev[c_nseg-1] | w_seg_sum[c_nseg-1];
    w_ovf       = w_cmsb[c_nseg-1] ^ w_co[c_nseg-1];
    w_final_sum = w_raw_sum;
    if (w_sat_in[c_nseg-1] && w_ovf) begin
      w_final_sum = w_a_in[c_nseg-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_sat  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < c_nseg; k++) begin
        r_ctl[k].valid <= w_vld_in[k];
        r_ctl[k].carry <= w_co[k];
        r_a[k]         <= w_a_in[k];
        r_b[k]         <= w_b_in[k];
        r_sat[k]       <= w_sat_in[k];
        r_sum[k]       <= w_sum_prev[k] | w_seg_sum[k];
      end
      r_sum[c_nseg-1] <= w_final_sum;
      r_cout          <= w_co[c_nseg-1];
      r_ovf           <= w_ovf;
      r_zero          <= ~|w_final_sum;
    end
  end

  assign sum       = r_sum[c_nseg-1];
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign out_valid = r_ctl[c_nseg-1].valid;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_addsub : directed + randomized scoreboard bench          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pipelined_addsub;

  localparam int W = 34;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         sat_v = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;
  logic         out_valid;
  logic         out_ready;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  logic last_acc = 1'b0;

  always #5 clk = ~clk;

  pipelined_addsub #(
    .WIDTH (W),
    .SEG_W (17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    .sat       (sat_v),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference: plain wide arithmetic; overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tcin, input logic tsub, input logic tsat);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] beff;
    beff   = tsub ? ~tb_ : tb_;
    full   = {1'b0, ta} + {1'b0, beff} + (W+1)'(tsub ? 1'b1 : tcin);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == beff[W-1]) && (full[W-1] != ta[W-1]);
    if (tsat && e.ovf)
      e.sum = ta[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tcin, input logic tsub, input logic tv);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = tv;
  endtask

  // One clock: score the output transfer, then record the accepted op.
  task automatic tick();
    exp_t e;
    #1;
    last_acc = in_valid & in_ready & ~rst;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        n_popped++;
        check("sb_sum", sum, e.sum);
        check("sb_cout", cout, e.cout);
        check("sb_overflow", overflow, e.ovf);
        check("sb_zero", zero, e.zero);
      end
    end
    @(posedge clk);
    #1;
    if (rst) q.delete();
    else if (last_acc) q.push_back(model(a, b, cin, sub, sat_v));
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic ez);
    drive(ta, tb_, tcin, tsub, 1'b1);
    tick();
    check({tag, "_accepted"}, last_acc, 1'b1);
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    check({tag, "_not_early"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_overflow"}, overflow, eo);
    check({tag, "_zero"}, zero, ez);
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  initial begin
    logic [W-1:0] sa [8];
    logic [W-1:0] sb [8];
    logic         sc [8];
    logic         ss [8];
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf, held_zero, have_held;
    int           sent, base;

    rst = 1'b1; out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_sum", sum, '0);
    check("reset_cout", cout, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_zero", zero, 1'b0);

    directed("add_ovf", 34'h1_FFFF_FFFF, 34'h1, 1'b0, 1'b0, 34'h2_0000_0000, 1'b0, 1'b1, 1'b0);
    directed("add_wrap", 34'h3_FFFF_FFFF, 34'h1, 1'b0, 1'b0, 34'h0, 1'b1, 1'b0, 1'b1);
    directed("sub_neg", 34'h5, 34'h7, 1'b1, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) begin
      sa[i] = W'({$urandom(), $urandom()});
      sb[i] = W'({$urandom(), $urandom()});
      sc[i] = 1'($urandom_range(0, 1));
      ss[i] = 1'($urandom_range(0, 1));
    end
    tick();
    base = n_popped; sent = 0; have_held = 1'b0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
    for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      drive(sa[sent], sb[sent], sc[sent], ss[sent], 1'b1);
      #1;
      if (!out_ready) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
      end
      if (have_held) begin
        check("stall_hold_sum", sum, held_sum);
        check("stall_hold_cout", cout, held_cout);
        check("stall_hold_overflow", overflow, held_ovf);
        check("stall_hold_zero", zero, held_zero);
      end
      have_held = !out_ready;
      held_sum = sum; held_cout = cout; held_ovf = overflow; held_zero = zero;
      tick();
      if (last_acc) sent++;
    end
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check("stream_sent", sent, 8);
    check("stream_results", n_popped - base, 8);
    check("stream_drained", q.size(), 0);

    // Reset while two operations are in flight.
    drive(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 1'b0, 1'b0, 1'b1);
    tick();
    drive(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 1'b1, 1'b1, 1'b1);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, '0);
    check("midrst_cout", cout, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_zero", zero, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_ghost", out_valid, 1'b0);
    end
    directed("post_rst", 34'h0_0001_2345, 34'h1, 1'b0, 1'b0, 34'h0_0001_2346, 1'b0, 1'b0, 1'b0);

`ifdef PIPELINED_ADDSUB_SATURATE_EN
    sat_v = 1'b1;
    directed("sat_pos", 34'h1_FFFF_FFFF, 34'h1, 1'b0, 1'b0, 34'h1_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    directed("sat_neg", 34'h2_0000_0000, 34'h1, 1'b0, 1'b1, 34'h2_0000_0000, 1'b1, 1'b1, 1'b0);
    sat_v = 1'b0;
`endif

    // Random traffic with random bubbles and backpressure.
    base = n_popped;
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
      sat_v = 1'($urandom_range(0, 1));
`endif
      drive(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
      tick();
    end
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check("random_drained", q.size(), 0);
    tick();
    check("random_idle_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined signed/unsigned adder-subtractor; next generation of the team's fixed-width ripple adder.
- Operand width is split into SEG_W-bit segments, one segment per pipeline stage, with carries registered between stages, so clock rate is independent of WIDTH.
- A valid/ready handshake allows full-throughput streaming with backpressure.
- Sits in the datapath between the operand-select logic and the result/flag writeback.

Parameters:
- WIDTH, 34, operand and result width in bits (>=2).
- SEG_W, 17, bits added per pipeline stage (1..WIDTH). NSEG = ceil(WIDTH/SEG_W); the last segment holds the remaining bits.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0; evaluated after saturation when SATURATE_EN is defined
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Reset: all stage valid bits and out_valid = 0; sum, cout, overflow, zero = 0. Any in-flight operations are discarded. in_ready = 1 in the first cycle after reset.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv (combinational). When adv = 0, every pipeline register holds its value.
- Transfer in: in_valid & in_ready on a rising edge.
- Stage 0: computes segment 0 from a[SEG_W-1:0], the effective b (b or ~b) and the effective carry-in (cin, or 1 when sub). It registers the segment sum, carry, valid bit, and the upper a/b bits still to be added.
- Stage k (1..NSEG-1): adds segment k using the registered carry from stage k-1. Lower sum bits already computed travel forward in skew registers.
- The final stage computes cout, overflow and zero.
- Latency: NSEG cycles from input acceptance to out_valid with out_ready held high. Throughput: one result per cycle.
- Bubbles (in_valid = 0) propagate as stage valid = 0. Data registers may update freely on bubbles, but sum and the flags must hold while out_valid = 1 & out_ready = 0.
- out_valid & ~out_ready: all outputs stable and no input accepted. Inputs offered during the stall are taken on the first cycle adv returns to 1.
- Arithmetic is modulo 2^WIDTH. cout and overflow are both always computed; the consumer selects signed or unsigned interpretation.
- NSEG = 1: a single registered stage, latency 1.
- Reset asserted mid-stream overrides advance; no result from before reset ever appears at the output.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SATURATE_EN.
- Defined:
  - Adds input port sat (1 bit), captured with the operands and carried down the pipeline.
  - When sat = 1 and signed overflow occurs, sum = most-positive value (0 followed by ones) if the operands' effective sign bits were both 0, else most-negative value (1 followed by zeros).
  - overflow and cout still report the raw, unsaturated condition.
  - Latency is unchanged; saturation is applied in the final stage.
- Undefined: sat port absent; sum is always the wrapped result.

Decomposition:
- Package pipelined_addsub_pkg:
  - function computing NSEG from WIDTH and SEG_W
  - localparam for the last-segment width
  - typedef of the per-stage carry/valid record
- One sub-module, addsub_seg: combinational SEG_W-bit adder (inputs a, b, ci; outputs s, co, c_msb_in). Instantiated once per stage via generate.

Test Plan (WIDTH=34, SEG_W=17, latency 2, out_ready=1 unless stated):
- 0x1_FFFF_FFFF + 1, sub=0, cin=0 -> two cycles later sum=0x2_0000_0000, cout=0, overflow=1, zero=0.
- 0x3_FFFF_FFFF + 1 -> sum=0, cout=1, overflow=0, zero=1. Verifies the carry crossing the bit-16/17 stage boundary.
- sub=1, a=5, b=7, cin=1 (ignored) -> sum=0x3_FFFF_FFFE, cout=0, overflow=0.
- Back-to-back stream of 8 random operations with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, outputs held, all 8 results in order, none lost or duplicated.
- rst pulsed one cycle while 2 ops are in flight -> out_valid=0 and all outputs 0 next cycle. The in-flight results never appear; the next op appears 2 cycles after acceptance.
- With PIPELINED_ADDSUB_SATURATE_EN, sat=1: 0x1_FFFF_FFFF + 1 -> sum=0x1_FFFF_FFFF, overflow=1. Then 0x2_0000_0000 - 1 -> sum=0x2_0000_0000, overflow=1.
